// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel driver constants and scheduler state encoding
package pixel_pkg;

  localparam int COLOR_W   = 24;

  // Driver bit timing in clock cycles, and bit/latch counts per command
  localparam int TCK_ZR_HI = 20;
  localparam int TCK_ON_HI = 40;
  localparam int TCK_CYCLE = 63;
  localparam int CNT_COLOR = 24;
  localparam int CNT_RESET = 4000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PUSH  = 3'd3,
    LATCH = 3'd4
  } sched_state_e;

endpackage

// File: rtl/color_scaler.sv
// rtl/color_scaler.sv - per-byte brightness scaling of a 24-bit colour
module color_scaler
  import pixel_pkg::*;
(
  input  logic [COLOR_W-1:0] color_in,
  input  logic [7:0]         brightness,
  output logic [COLOR_W-1:0] color_out
);

  // brightness+1 so that 255 is an exact pass-through after the >>8
  logic [8:0] factor;
  assign factor = {1'b0, brightness} + 9'd1;

  for (genvar i = 0; i < COLOR_W / 8; i++) begin : g_byte
    logic [15:0] prod;
    assign prod                = {8'd0, color_in[8*i +: 8]} * {7'd0, factor};
    assign color_out[8*i +: 8] = 8'(prod >> 8);
  end

endmodule

// File: rtl/strip_scheduler.sv
// rtl/strip_scheduler.sv - frame sequencer feeding pixel_driver from the frame buffer
module strip_scheduler
  import pixel_pkg::*;
#(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 auto_run,
  input  logic                 bank_sel,
  input  logic [7:0]           brightness,
  output logic                 rd_en,
  output logic                 rd_bank,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [COLOR_W-1:0]   rd_data,
  output logic [COLOR_W-1:0]   drv_color,
  output logic                 drv_reset,
  output logic                 drv_valid,
  input  logic                 drv_ready,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);

  sched_state_e         state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [7:0]           bright_q, bright_d;
  logic                 rd_en_q, rd_en_d;
  logic [COLOR_W-1:0]   drv_color_q, drv_color_d;
  logic                 drv_reset_q, drv_reset_d;
  logic                 drv_valid_q, drv_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic [COLOR_W-1:0]   scaled;
  logic                 accept;

  assign accept = drv_valid_q && drv_ready;

  color_scaler u_scaler (
    .color_in   (rd_data),
    .brightness (bright_q),
    .color_out  (scaled)
  );

  // Next-state and output-register logic for the frame sequencer
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_bank_d    = rd_bank_q;
    bright_d     = bright_q;
    rd_en_d      = 1'b0;
    drv_color_d  = drv_color_q;
    drv_reset_d  = drv_reset_q;
    drv_valid_d  = drv_valid_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_bank_d = bank_sel;
          bright_d  = brightness;
          addr_d    = '0;
          rd_en_d   = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        drv_color_d = scaled;
        drv_reset_d = 1'b0;
        drv_valid_d = 1'b1;
        state_d     = PUSH;
      end
      PUSH: begin
        if (accept) begin
          if (addr_q != LAST_ADDR) begin
            addr_d      = addr_q + ADDR_BITS'(1);
            drv_valid_d = 1'b0;
            rd_en_d     = 1'b1;
            state_d     = FETCH;
          end else begin
            // Latch command goes out back-to-back with the last pixel
            drv_reset_d = 1'b1;
            drv_color_d = '0;
            drv_valid_d = 1'b1;
            state_d     = LATCH;
          end
        end
      end
      LATCH: begin
        if (accept) begin
          drv_valid_d  = 1'b0;
          frame_done_d = 1'b1;
          if (auto_run) begin
            rd_bank_d = bank_sel;
            bright_d  = brightness;
            addr_d    = '0;
            rd_en_d   = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_bank_q    <= 1'b0;
      bright_q     <= 8'd0;
      rd_en_q      <= 1'b0;
      drv_color_q  <= '0;
      drv_reset_q  <= 1'b0;
      drv_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_bank_q    <= rd_bank_d;
      bright_q     <= bright_d;
      rd_en_q      <= rd_en_d;
      drv_color_q  <= drv_color_d;
      drv_reset_q  <= drv_reset_d;
      drv_valid_q  <= drv_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_bank    = rd_bank_q;
  assign rd_addr    = addr_q;
  assign drv_color  = drv_color_q;
  assign drv_reset  = drv_reset_q;
  assign drv_valid  = drv_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
